// File: rtl/top_artyx.sv
// 24-hour BCD clock driving an 8-digit multiplexed seven-segment display.
// Layout HH-MM-SS; anodes and segments are active-low and registered.
module top_artyx #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       CLK100MHZ,
  input  logic       BTNC,
  output logic [7:0] AN,
  output logic       CA,
  output logic       CB,
  output logic       CC,
  output logic       CD,
  output logic       CE,
  output logic       CF,
  output logic       CG
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_DIV - 1);
  localparam logic [3:0]    DASH     = 4'hA;

  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] ref_cnt;
  logic [2:0]    dig;
  logic [3:0]    s_u, s_t, m_u, m_t, h_u, h_t;
  logic [6:0]    seg;

  logic       tick, ref_adv, s_carry, m_carry;
  logic [3:0] cur_val;

  // Segment pattern {a,b,c,d,e,f,g}, lit segments driven low
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      DASH:    seg7 = 7'b1111110;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Carry chain and digit select from the current (pre-edge) state
  always_comb begin
    tick    = (tick_cnt == TICK_MAX);
    ref_adv = (ref_cnt == REF_MAX);
    s_carry = tick && (s_t == 4'd5) && (s_u == 4'd9);
    m_carry = s_carry && (m_t == 4'd5) && (m_u == 4'd9);
    cur_val = DASH;
    case (dig)
      3'd7:    cur_val = h_t;
      3'd6:    cur_val = h_u;
      3'd4:    cur_val = m_t;
      3'd3:    cur_val = m_u;
      3'd1:    cur_val = s_t;
      3'd0:    cur_val = s_u;
      default: cur_val = DASH;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (BTNC) begin
      tick_cnt <= '0;
      ref_cnt  <= '0;
      dig      <= 3'd0;
      s_u      <= 4'd0;
      s_t      <= 4'd0;
      m_u      <= 4'd0;
      m_t      <= 4'd0;
      h_u      <= 4'd0;
      h_t      <= 4'd0;
      AN       <= 8'hFF;
      seg      <= 7'b1111111;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      ref_cnt  <= ref_adv ? '0 : ref_cnt + RW'(1);
      if (ref_adv) dig <= dig + 3'd1;

      if (tick) begin
        if (s_u == 4'd9) begin
          s_u <= 4'd0;
          s_t <= (s_t == 4'd5) ? 4'd0 : s_t + 4'd1;
        end else begin
          s_u <= s_u + 4'd1;
        end
      end

      if (s_carry) begin
        if (m_u == 4'd9) begin
          m_u <= 4'd0;
          m_t <= (m_t == 4'd5) ? 4'd0 : m_t + 4'd1;
        end else begin
          m_u <= m_u + 4'd1;
        end
      end

      // Hours roll 23 -> 00 in the same edge as the minute carry
      if (m_carry) begin
        if ((h_t == 4'd2) && (h_u == 4'd3)) begin
          h_t <= 4'd0;
          h_u <= 4'd0;
        end else if (h_u == 4'd9) begin
          h_u <= 4'd0;
          h_t <= h_t + 4'd1;
        end else begin
          h_u <= h_u + 4'd1;
        end
      end

      AN  <= ~(8'b1 << dig);
      seg <= seg7(cur_val);
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg;

endmodule

// File: tb/tb_top_artyx.sv
// Bench for top_artyx: three instances with different dividers, checked
// against an arithmetic reference (time and digit derived from edge count).
module tb_top_artyx;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  typedef struct {
    int         inst;
    int         k;
    logic [7:0] an;
    logic [6:0] seg;
  } vec_t;

  localparam logic [6:0] S0    = 7'b0000001;
  localparam logic [6:0] S1    = 7'b1001111;
  localparam logic [6:0] S2    = 7'b0010010;
  localparam logic [6:0] S3    = 7'b0000110;
  localparam logic [6:0] S9    = 7'b0000100;
  localparam logic [6:0] SDASH = 7'b1111110;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic [7:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  top_artyx #(.TICK_DIV(1000), .REFRESH_DIV(2)) u_a (
    .CLK100MHZ(clk), .BTNC(rst_a), .AN(an_a),
    .CA(seg_a[6]), .CB(seg_a[5]), .CC(seg_a[4]), .CD(seg_a[3]),
    .CE(seg_a[2]), .CF(seg_a[1]), .CG(seg_a[0])
  );

  top_artyx #(.TICK_DIV(4), .REFRESH_DIV(5)) u_b (
    .CLK100MHZ(clk), .BTNC(rst_b), .AN(an_b),
    .CA(seg_b[6]), .CB(seg_b[5]), .CC(seg_b[4]), .CD(seg_b[3]),
    .CE(seg_b[2]), .CF(seg_b[1]), .CG(seg_b[0])
  );

  top_artyx #(.TICK_DIV(1), .REFRESH_DIV(1)) u_c (
    .CLK100MHZ(clk), .BTNC(rst_c), .AN(an_c),
    .CA(seg_c[6]), .CB(seg_c[5]), .CC(seg_c[4]), .CD(seg_c[3]),
    .CE(seg_c[2]), .CF(seg_c[1]), .CG(seg_c[0])
  );

  function automatic logic [6:0] enc(input int v);
    case (v)
      0: enc = 7'b0000001;  1: enc = 7'b1001111;
      2: enc = 7'b0010010;  3: enc = 7'b0000110;
      4: enc = 7'b1001100;  5: enc = 7'b0100100;
      6: enc = 7'b0100000;  7: enc = 7'b0001111;
      8: enc = 7'b0000000;  9: enc = 7'b0000100;
      default: enc = 7'b1111110;
    endcase
  endfunction

  // Output seen after free edge k reflects the state after k-1 free edges
  function automatic exp_t model(input int k, input int tdiv, input int rdiv);
    exp_t e;
    int n, secs, d, hh, mm, ss, v;
    n    = k - 1;
    secs = (n / tdiv) % 86400;
    d    = (n / rdiv) % 8;
    hh   = secs / 3600;
    mm   = (secs / 60) % 60;
    ss   = secs % 60;
    case (d)
      7: v = hh / 10;
      6: v = hh % 10;
      4: v = mm / 10;
      3: v = mm % 10;
      1: v = ss / 10;
      0: v = ss % 10;
      default: v = 10;
    endcase
    e.an  = ~(8'b1 << d);
    e.seg = enc(v);
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] ga, input logic [6:0] gs,
                       input logic [7:0] ea, input logic [6:0] es);
    n_checks++;
    if (ga !== ea || gs !== es) begin
      n_fail++;
      $display("FAIL %s: got AN=%h seg=%b, expected AN=%h seg=%b", name, ga, gs, ea, es);
    end
  endtask

  task automatic get_out(input int inst, output logic [7:0] a, output logic [6:0] s);
    case (inst)
      0:       begin a = an_a; s = seg_a; end
      1:       begin a = an_b; s = seg_b; end
      default: begin a = an_c; s = seg_c; end
    endcase
  endtask

  task automatic run_phase(input int inst, input int nedges);
    int td, rd;
    logic [7:0] a;
    logic [6:0] s;
    exp_t e;
    td = (inst == 0) ? 1000 : (inst == 1) ? 4 : 1;
    rd = (inst == 0) ? 2 : (inst == 1) ? 5 : 1;
    for (int k = 1; k <= nedges; k++) begin
      sb.push_back(model(k, td, rd));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      get_out(inst, a, s);
      check($sformatf("model inst%0d k%0d", inst, k), a, s, e.an, e.seg);
      foreach (vecs[i])
        if (vecs[i].inst == inst && vecs[i].k == k)
          check($sformatf("vec inst%0d k%0d", inst, k), a, s, vecs[i].an, vecs[i].seg);
    end
  endtask

  initial begin
    logic [7:0] a;
    logic [6:0] s;

    // Hand-derived expectations: {instance, free edge, AN, segments}
    vecs.push_back('{0, 1,  8'hFE, S0});
    vecs.push_back('{0, 2,  8'hFE, S0});
    vecs.push_back('{0, 3,  8'hFD, S0});
    vecs.push_back('{0, 5,  8'hFB, SDASH});
    vecs.push_back('{0, 7,  8'hF7, S0});
    vecs.push_back('{0, 9,  8'hEF, S0});
    vecs.push_back('{0, 11, 8'hDF, SDASH});
    vecs.push_back('{0, 13, 8'hBF, S0});
    vecs.push_back('{0, 15, 8'h7F, S0});
    vecs.push_back('{0, 16, 8'h7F, S0});
    vecs.push_back('{0, 17, 8'hFE, S0});
    vecs.push_back('{1, 4,  8'hFE, S0});
    vecs.push_back('{1, 5,  8'hFE, S1});
    vecs.push_back('{1, 40, 8'h7F, S0});
    vecs.push_back('{1, 41, 8'hFE, S0});
    vecs.push_back('{1, 45, 8'hFE, S1});
    vecs.push_back('{1, 46, 8'hFD, S1});
    vecs.push_back('{2, 86396, 8'hF7, S9});
    vecs.push_back('{2, 86398, 8'hDF, SDASH});
    vecs.push_back('{2, 86399, 8'hBF, S3});
    vecs.push_back('{2, 86400, 8'h7F, S2});
    vecs.push_back('{2, 86401, 8'hFE, S0});
    vecs.push_back('{2, 86402, 8'hFD, S0});

    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      check("reset a", an_a, seg_a, 8'hFF, BLANK);
      check("reset b", an_b, seg_b, 8'hFF, BLANK);
      check("reset c", an_c, seg_c, 8'hFF, BLANK);
    end

    rst_a = 1'b0;
    run_phase(0, 20);
    check("held reset b", an_b, seg_b, 8'hFF, BLANK);
    check("held reset c", an_c, seg_c, 8'hFF, BLANK);

    // Run to 00:01:37 plus two cycles into the next second, then reset
    rst_b = 1'b0;
    run_phase(1, 390);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    get_out(1, a, s);
    check("midrun reset b", a, s, 8'hFF, BLANK);
    rst_b = 1'b0;
    run_phase(1, 50);

    rst_c = 1'b0;
    run_phase(2, 86402);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/top_artyx.md
TOP_ARTYX -- requirements
Module: top_artyx

Interface
REQ-001 Parameter TICK_DIV, default 100000000: clock cycles per one-second tick, >=1.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles each display digit stays active, >=1.
REQ-003 The clock port SHALL be CLK100MHZ, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The reset port SHALL be BTNC, input, 1 bit: synchronous, active-high reset.
REQ-005 AN SHALL be an output, 8 bits: digit anodes, active-low, with AN[i] selecting digit i.
REQ-006 Outputs CA, CB, CC, CD, CE, CF and CG SHALL each be 1 bit: segments a..g, active-low, shared by all digits.

Function
REQ-007 Timekeeping SHALL use BCD registers for hours (00-23), minutes (00-59) and seconds (00-59).
REQ-008 Tick generation:
- tick_cnt counts 0..TICK_DIV-1.
- On the edge where tick_cnt==TICK_DIV-1, tick_cnt SHALL return to 0 and seconds SHALL increment on that same edge.
REQ-009 Seconds 59 SHALL wrap to 00 and increment minutes in the same cycle.
REQ-010 Minutes 59 with a seconds carry SHALL wrap to 00 and increment hours.
REQ-011 Hours 23 with a minutes carry SHALL wrap to 00, so 23:59:59 becomes 00:00:00 in a single tick.
REQ-012 BCD rule: a units digit of 9 SHALL wrap to 0 and carry into the tens digit; no non-BCD value SHALL ever be held.
REQ-013 Scan timing:
- ref_cnt counts 0..REFRESH_DIV-1.
- On the edge where ref_cnt==REFRESH_DIV-1, ref_cnt SHALL return to 0 and the 3-bit digit index dig SHALL increment, wrapping 7->0.
REQ-014 Digit map:
- 7 = hours tens, 6 = hours units, 5 = dash.
- 4 = minutes tens, 3 = minutes units, 2 = dash.
- 1 = seconds tens, 0 = seconds units.
REQ-015 Outputs SHALL be registered. On every non-reset edge:
- AN <= ~(8'b1 << dig).
- Segments <= encoding of the digit selected by the pre-edge dig and time values.
- This gives one cycle of latency.
REQ-016 Exactly one AN bit SHALL be low on every cycle after the first post-reset edge.
REQ-017 Segment encoding (lit segments, driven 0; all others 1):
- 0 = abcdef, 1 = bc, 2 = abdeg, 3 = abcdg, 4 = bcfg.
- 5 = acdfg, 6 = acdefg, 7 = abc, 8 = abcdefg, 9 = abcdfg.
- dash = g.
REQ-018 The design SHALL have no other inputs and no time-set function.
REQ-019 The tick and scan counters SHALL be independent; a tick coinciding with a digit advance SHALL apply both on the same edge.
REQ-020 A displayed digit SHALL reflect a new time value no later than one cycle after that value is registered.

Reset
REQ-021 On any rising edge with BTNC=1, the design SHALL:
- set time to 00:00:00 and clear tick_cnt, ref_cnt and dig;
- drive AN=8'hFF and CA..CG=1 (all blank).
REQ-022 Reset SHALL dominate simultaneous tick, carry and scan events.
REQ-023 Reset asserted mid-count SHALL take effect on the next edge, with no partial increment.
REQ-024 BTNC held high for N edges SHALL keep all outputs blank for those N edges.
REQ-025 At the first non-reset edge after release:
- AN SHALL be 8'hFE.
- CA..CF SHALL be 0 and CG SHALL be 1 (digit 0 shows '0').

Verification
REQ-026 Reset check: BTNC=1 for 2 edges, then 0 -> AN=FF and segments all 1 during reset; after the first free edge, AN=FE with segments showing '0'.
REQ-027 Scan check: TICK_DIV=1000, REFRESH_DIV=2 -> AN sequence FE,FE,FD,FD,FB,...,7F,7F,FE (rotating); digits 5 and 2 show only CG=0; digit 7 shows '0'.
REQ-028 Tick check: TICK_DIV=4 -> seconds reach 01 after 4 free edges and 10 after 40; the seconds-units digit shows '1' (CB=CC=0, all other segments 1) while it is scanned.
REQ-029 Rollover check: TICK_DIV=1, run 86400 free edges -> time 00:00:00 again; at edge 86399 the time is 23:59:59 and the display shows 2,3,-,5,9,-,5,9.
REQ-030 Mid-run reset check: assert BTNC at time 00:01:37 -> next edge shows time 00:00:00 and blank outputs; counting restarts from 0 after release.
REQ-031 Simultaneity check: a tick coinciding with a digit advance -> both apply on the same edge, and the registered segments follow REQ-015 latency.
